// File: rtl/picomips_pkg.sv
// Shared definitions for the picoMIPS run controller: state encoding,
// default timing constants and a counter-width helper.
package picomips_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10,
        HALTED = 2'b11
    } state_e;

    // 10 Hz CPU rate from a 50 MHz board clock; 10 ms button settle time.
    localparam int DIV_DEFAULT = 5_000_000;
    localparam int DEB_DEFAULT = 500_000;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a stability debouncer; emits a single
// pulse each time the debounced level rises.
module sync_debounce
    import picomips_pkg::*;
#(
    parameter int DEB = DEB_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    localparam int CW = cnt_width(DEB);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

    logic          meta_q, sync_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
                rise_d  = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: reset is synchronous and active-low, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/picomips_run_ctrl.sv
// Run/step/halt controller producing a one-cycle CPU clock enable from the
// board switches, so the CPU stays on the single system clock.
module picomips_run_ctrl
    import picomips_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int DEB   = DEB_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             halt_in,
    output logic             cpu_en,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int PW = cnt_width(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    state_e           state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_meta_q, run_s_q;
    logic             step_pulse;
    logic             tick;
    logic             en;

    sync_debounce #(
        .DEB(DEB)
    ) u_step (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (step_btn),
        .rise_o (step_pulse)
    );

    always_comb begin
        state_d = state_q;
        pre_d   = '0;
        tick    = 1'b0;
        en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_s_q)         state_d = RUN;
                else if (step_pulse) state_d = STEP;
            end
            RUN: begin
                tick = (pre_q == PRE_LAST);
                // A halt or a dropped run switch on the tick cycle suppresses the pulse.
                if (halt_in)       state_d = HALTED;
                else if (!run_s_q) state_d = IDLE;
                else               en      = tick;
            end
            STEP: begin
                en      = 1'b1;
                state_d = halt_in ? HALTED : IDLE;
            end
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase

        // Prescaler only advances while staying in RUN, so every entry starts at 0.
        if (state_q == RUN && state_d == RUN) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end

        cnt_d = en ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            run_meta_q <= 1'b0;
            run_s_q    <= 1'b0;
            state_q    <= IDLE;
            pre_q      <= '0;
            cnt_q      <= '0;
        end else begin
            run_meta_q <= run_sw;
            run_s_q    <= run_meta_q;
            state_q    <= state_d;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
        end
    end

    assign cpu_en    = en;
    assign state_o   = state_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_picomips_run_ctrl.sv
// Directed bench for picomips_run_ctrl with DIV=4, DEB=3, CNT_W=4.
module tb_picomips_run_ctrl;
    import picomips_pkg::*;

    logic       clk;
    logic       reset;
    logic       run_sw;
    logic       step_btn;
    logic       halt_in;
    logic       cpu_en;
    logic [1:0] state_o;
    logic [3:0] cycle_cnt;

    int n_chk = 0;
    int n_bad = 0;

    picomips_run_ctrl #(
        .DIV   (4),
        .DEB   (3),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run_sw    (run_sw),
        .step_btn  (step_btn),
        .halt_in   (halt_in),
        .cpu_en    (cpu_en),
        .state_o   (state_o),
        .cycle_cnt (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Wait for n cpu_en pulses within a cycle budget; counter has updated on return.
    task automatic run_pulses(input int n, input string tag);
        int seen;
        int spent;
        seen  = 0;
        spent = 0;
        while (seen < n && spent < n * 4 + 10) begin
            if (cpu_en) seen++;
            cyc();
            spent++;
        end
        check(tag, 32'(seen), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n_step;
        int n_en;
        logic [7:0] bounce;

        reset    = 1'b0;
        run_sw   = 1'b0;
        step_btn = 1'b0;
        halt_in  = 1'b0;
        cyc();
        cyc();
        check("rst_state", 32'(state_o), 32'(IDLE));
        check("rst_en", 32'(cpu_en), 0);
        check("rst_cnt", 32'(cycle_cnt), 0);

        // Run switch held through reset must not act until release.
        run_sw = 1'b1;
        cyc();
        check("rst_holds_idle", 32'(state_o), 32'(IDLE));
        reset = 1'b1;
        n = 0;
        while (state_o != RUN && n < 6) begin
            cyc();
            n++;
        end
        check("run_entry_within_3", 32'(n <= 3 && state_o == RUN), 1);

        // First RUN cycle has prescaler 0: pulse on every 4th cycle.
        for (int j = 0; j < 12; j++) begin
            check("run_pulse_pattern", 32'(cpu_en), 32'((j % 4) == 3));
            cyc();
        end
        check("cnt_after_12", 32'(cycle_cnt), 3);

        // Halt coinciding with the tick: no pulse, then sticky HALTED.
        cyc();
        cyc();
        cyc();
        halt_in = 1'b1;
        #1;
        check("halt_on_tick_en", 32'(cpu_en), 0);
        check("halt_on_tick_state", 32'(state_o), 32'(RUN));
        cyc();
        halt_in = 1'b0;
        check("halted_state", 32'(state_o), 32'(HALTED));
        check("halted_cnt", 32'(cycle_cnt), 3);
        for (int i = 0; i < 12; i++) begin
            run_sw   = (i % 3) != 0;
            step_btn = i < 6;
            cyc();
            check("halted_sticky", 32'({state_o, cpu_en}), 32'({HALTED, 1'b0}));
        end
        check("halted_cnt_kept", 32'(cycle_cnt), 3);

        // Bouncing step button in IDLE: exactly one STEP and one pulse.
        reset    = 1'b0;
        run_sw   = 1'b0;
        step_btn = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        cyc();
        cyc();
        check("idle_after_rst", 32'(state_o), 32'(IDLE));
        check("cnt_after_rst", 32'(cycle_cnt), 0);
        bounce = 8'b1111_1101;
        n_step = 0;
        n_en   = 0;
        for (int i = 0; i < 20; i++) begin
            step_btn = (i < 8) ? bounce[i] : 1'b0;
            #1;
            if (state_o == STEP) n_step++;
            if (cpu_en) n_en++;
            cyc();
        end
        check("step_count", 32'(n_step), 1);
        check("step_en_count", 32'(n_en), 1);
        check("step_back_idle", 32'(state_o), 32'(IDLE));
        check("step_cnt", 32'(cycle_cnt), 1);

        // Counter wrap: 1 -> 15, then 16 more pulses wrap through 0 back to 15.
        run_sw = 1'b1;
        run_pulses(14, "pulses_to_15");
        check("cnt_15", 32'(cycle_cnt), 15);
        run_pulses(1, "pulse_wrap");
        check("cnt_wrap_0", 32'(cycle_cnt), 0);
        run_pulses(15, "pulses_again");
        check("cnt_back_15", 32'(cycle_cnt), 15);

        // Reset between ticks takes effect at that edge.
        cyc();
        reset = 1'b0;
        cyc();
        check("midrun_rst_state", 32'(state_o), 32'(IDLE));
        check("midrun_rst_en", 32'(cpu_en), 0);
        check("midrun_rst_cnt", 32'(cycle_cnt), 0);

        // run_sw lowered so that run_s falls exactly on the tick cycle.
        reset = 1'b1;
        n = 0;
        while (state_o != RUN && n < 6) begin
            cyc();
            n++;
        end
        check("rerun_entry", 32'(state_o), 32'(RUN));
        cyc();
        run_sw = 1'b0;
        cyc();
        cyc();
        check("drop_tick_en", 32'(cpu_en), 0);
        cyc();
        check("drop_to_idle", 32'(state_o), 32'(IDLE));
        check("drop_cnt", 32'(cycle_cnt), 0);

        // Re-entering RUN: pulse on the 4th RUN cycle.
        run_sw = 1'b1;
        n = 0;
        while (state_o != RUN && n < 6) begin
            cyc();
            n++;
        end
        n = 0;
        while (!cpu_en && n < 8) begin
            cyc();
            n++;
        end
        check("reentry_gap", 32'(n), 3);
        run_sw = 1'b0;
        cyc();
        check("reentry_cnt", 32'(cycle_cnt), 1);
        n = 0;
        while (state_o != IDLE && n < 6) begin
            cyc();
            n++;
        end
        check("back_idle", 32'(state_o), 32'(IDLE));

        // STEP with halt_in on its cycle goes to HALTED.
        step_btn = 1'b1;
        n = 0;
        while (state_o != STEP && n < 15) begin
            cyc();
            n++;
        end
        check("step2_seen", 32'(state_o), 32'(STEP));
        halt_in = 1'b1;
        #1;
        check("step2_en", 32'(cpu_en), 1);
        cyc();
        halt_in  = 1'b0;
        step_btn = 1'b0;
        check("step_halt_state", 32'(state_o), 32'(HALTED));
        check("step_halt_cnt", 32'(cycle_cnt), 2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/picomips_run_ctrl.md
PICOMIPS_RUN_CTRL -- requirements
Module: picomips_run_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 5_000_000, meaning fastclk cycles per CPU cycle in RUN (10 Hz at 50 MHz).
REQ-002 SHALL have parameter DEB, default 500_000, meaning cycles step_btn must be stable to count as a debounced level.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of cycle_cnt.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-006 run_sw  input  1  asynchronous run/stop switch level (1 = run).
REQ-007 step_btn  input  1  asynchronous, bouncing single-step request.
REQ-008 halt_in  input  1  synchronous halt indication from the CPU (halt opcode executed).
REQ-009 cpu_en  output  1  one-cycle clock-enable pulse; each pulse advances the CPU by one instruction.
REQ-010 state_o  output  2  current controller state encoding.
REQ-011 cycle_cnt  output  CNT_W  number of cpu_en pulses issued since reset.

Function
REQ-012 run_sw and step_btn SHALL each pass through a 2-flop synchronizer before any use; run_s and step_s denote the synchronized values.
REQ-013 step_s SHALL be debounced: the debounced level updates only after step_s holds a new value for DEB consecutive cycles.
REQ-014 step_pulse SHALL be a one-cycle pulse on each 0->1 transition of the debounced level; 1->0 transitions produce none.
REQ-015 States SHALL be IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALTED=2'b11; state_o reflects the registered state.
REQ-016 IDLE: if run_s=1 -> RUN; else if step_pulse -> STEP; else stay in IDLE.
REQ-017 RUN: if halt_in=1 -> HALTED; else if run_s=0 -> IDLE; else stay in RUN. step_pulse SHALL be ignored in RUN.
REQ-018 Prescaler SHALL clear to 0 on every entry to RUN and count 0..DIV-1 while in RUN; tick is asserted when count=DIV-1, after which the count wraps to 0.
REQ-019 In RUN, cpu_en SHALL be asserted on the cycle tick is asserted, unless halt_in=1 or run_s=0 on that cycle; in those cases halt wins and no pulse is issued.
REQ-020 STEP SHALL last exactly one cycle with cpu_en=1, then go to HALTED if halt_in=1 on that cycle, otherwise to IDLE.
REQ-021 HALTED SHALL be sticky: cpu_en=0 and the state holds regardless of run_s, step_pulse or halt_in until reset.
REQ-022 cpu_en SHALL never be asserted in IDLE or HALTED and SHALL never be high on two consecutive cycles when DIV>=2.
REQ-023 cycle_cnt SHALL increment by 1 on each cycle cpu_en=1 and wrap from all-ones to 0.
REQ-024 First cpu_en in RUN SHALL occur DIV cycles after the cycle on which the state becomes RUN.

Reset
REQ-025 On reset=0 at a clock edge: state IDLE, cpu_en=0, cycle_cnt=0, prescaler=0, synchronizer and debounce flops=0, debounce counter=0.
REQ-026 Reset applied mid-RUN or mid-STEP SHALL take effect at that edge and no cpu_en SHALL be issued on the following cycle.
REQ-027 After reset releases with run_sw held at 1, the block SHALL enter RUN no later than 3 cycles after release (synchronizer latency plus one transition).

Structure
REQ-028 A shared package picomips_pkg SHALL hold the state enum (IDLE/RUN/STEP/HALTED) and the default DIV/DEB constants.
REQ-029 Synchronizer plus debouncer SHALL be one sub-module, sync_debounce (parameter DEB), instantiated for step_btn; run_sw uses only the 2-flop synchronizer.
REQ-030 The block SHALL be placed between the board switches and the CPU clock enable, replacing a divided-clock scheme; the CPU stays on clk.

Verification (DIV=4, DEB=3, CNT_W=4)
REQ-031 reset=0 for 2 cycles, then run_sw=1 -> RUN within 3 cycles; cpu_en pulses every 4th cycle; cycle_cnt=3 after 12 cycles in RUN.
REQ-032 In RUN, assert halt_in on the same cycle as tick -> no cpu_en; state_o=2'b11; toggling run_sw/step_btn afterwards leaves the state and cycle_cnt unchanged.
REQ-033 In IDLE, step_btn bounces 1,0,1 then holds 1 for 5 cycles -> exactly one STEP, exactly one cpu_en, cycle_cnt+1, return to IDLE.
REQ-034 Run 16 pulses from cycle_cnt=15 -> wraps to 0 and continues counting to 15.
REQ-035 In RUN, pull reset low between two ticks -> next cycle state_o=00, cpu_en=0, cycle_cnt=0.
REQ-036 In RUN, drop run_sw on the cycle before tick -> IDLE, no pulse issued; raising run_sw again -> next pulse comes 4 cycles after re-entering RUN.
